// File: rtl/rs_arith_if.sv
// rs_arith_if: bus bundle for the arithmetic reservation station.
//   master : the dispatch / writeback / FU side that drives the station
//   slave  : the station itself (rs_arith)
// Groups:
//   flush                                   - discard all held and in-flight work
//   disp_*                                  - dispatch offer (valid/ready) and entry payload
//   wb_*                                    - result broadcast used for wakeup
//   fu_ready, iss_*                         - issue port toward the arith FU (registered)
//   count                                   - number of occupied entries
interface rs_arith_if #(
    parameter int ENTRIES = 4,
    parameter int PRN_W   = 7,
    parameter int ID_W    = 6
);
    localparam int CNT_W = $clog2(ENTRIES) + 1;

    logic                  flush;

    logic                  disp_valid;
    logic                  disp_ready;
    logic [31:0]           disp_inst;
    logic [ID_W-1:0]       disp_inst_id;
    logic [PRN_W-1:0]      disp_out_prn;
    logic [1:0][PRN_W-1:0] disp_src_prn;
    logic [1:0]            disp_src_rdy;
    logic [1:0][63:0]      disp_src_val;

    logic                  wb_valid;
    logic [PRN_W-1:0]      wb_prn;
    logic [63:0]           wb_data;

    logic                  fu_ready;
    logic                  iss_valid;
    logic [31:0]           iss_inst;
    logic [ID_W-1:0]       iss_inst_id;
    logic [PRN_W-1:0]      iss_out_prn;
    logic [1:0][63:0]      iss_op;

    logic [CNT_W-1:0]      count;

    modport master (
        output flush, disp_valid, disp_inst, disp_inst_id, disp_out_prn,
               disp_src_prn, disp_src_rdy, disp_src_val,
               wb_valid, wb_prn, wb_data, fu_ready,
        input  disp_ready, iss_valid, iss_inst, iss_inst_id, iss_out_prn,
               iss_op, count
    );

    modport slave (
        input  flush, disp_valid, disp_inst, disp_inst_id, disp_out_prn,
               disp_src_prn, disp_src_rdy, disp_src_val,
               wb_valid, wb_prn, wb_data, fu_ready,
        output disp_ready, iss_valid, iss_inst, iss_inst_id, iss_out_prn,
               iss_op, count
    );
endinterface

// File: rtl/rs_arith.sv
// rs_arith: collapsing-queue reservation station for the arithmetic FU.
// Entries are age ordered (index 0 oldest). Sources wake up on matching
// result broadcasts; the oldest entry with both sources ready issues into
// a registered issue port and the entries above it shift down.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - rs_arith_if.slave (dispatch, writeback, flush, issue, count)
module rs_arith #(
    parameter int ENTRIES = 4,
    parameter int PRN_W   = 7,
    parameter int ID_W    = 6
) (
    input  logic      clk,
    input  logic      rst,
    rs_arith_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES) + 1;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           inst;
        logic [ID_W-1:0]       inst_id;
        logic [PRN_W-1:0]      out_prn;
        logic [1:0][PRN_W-1:0] prn;
        logic [1:0]            rdy;
        logic [1:0][63:0]      val;
    } entry_t;

    entry_t                q  [ENTRIES];
    entry_t                qx [ENTRIES+1];   // q plus an empty slot on top for the shift
    entry_t                nq [ENTRIES];
    entry_t                din;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      widx;
    logic [ENTRIES-1:0]    elig;
    logic [IDX_W-1:0]      sel;
    logic                  disp_ready;
    logic                  issue;
    logic                  dispatch;

    logic                  iss_valid_q;
    logic [31:0]           iss_inst_q;
    logic [ID_W-1:0]       iss_inst_id_q;
    logic [PRN_W-1:0]      iss_out_prn_q;
    logic [1:0][63:0]      iss_op_q;

    // Space is judged from registered occupancy only; an issue in the same
    // cycle does not open a slot until the next cycle.
    assign disp_ready = (count_q != CNT_W'(ENTRIES));
    assign dispatch   = bus.disp_valid && disp_ready && !bus.flush;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_elig
        assign elig[g] = q[g].valid && (&q[g].rdy);
    end

    // Lowest-index eligible entry wins (oldest first).
    always_comb begin
        sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (elig[i]) sel = IDX_W'(i);
        end
    end

    assign issue = bus.fu_ready && !bus.flush && (|elig);

    // Incoming entry, with a same-cycle broadcast folded into non-ready sources.
    always_comb begin
        din         = '0;
        din.valid   = 1'b1;
        din.inst    = bus.disp_inst;
        din.inst_id = bus.disp_inst_id;
        din.out_prn = bus.disp_out_prn;
        for (int s = 0; s < 2; s++) begin
            din.prn[s] = bus.disp_src_prn[s];
            if (!bus.disp_src_rdy[s] && bus.wb_valid && bus.disp_src_prn[s] == bus.wb_prn) begin
                din.rdy[s] = 1'b1;
                din.val[s] = bus.wb_data;
            end else begin
                din.rdy[s] = bus.disp_src_rdy[s];
                din.val[s] = bus.disp_src_val[s];
            end
        end
    end

    // Next queue image: collapse above the issued slot, apply wakeup,
    // then drop the new entry at the first free slot after the collapse.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) qx[i] = q[i];
        qx[ENTRIES] = '0;
        widx = count_q - CNT_W'(issue);
        for (int i = 0; i < ENTRIES; i++) begin
            nq[i] = (issue && IDX_W'(i) >= sel) ? qx[i+1] : qx[i];
            for (int s = 0; s < 2; s++) begin
                if (bus.wb_valid && nq[i].valid && !nq[i].rdy[s] && nq[i].prn[s] == bus.wb_prn) begin
                    nq[i].rdy[s] = 1'b1;
                    nq[i].val[s] = bus.wb_data;
                end
            end
            if (dispatch && widx == CNT_W'(i)) nq[i] = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) q[i] <= '0;
            count_q       <= '0;
            iss_valid_q   <= 1'b0;
            iss_inst_q    <= '0;
            iss_inst_id_q <= '0;
            iss_out_prn_q <= '0;
            iss_op_q      <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) q[i].valid <= 1'b0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) q[i] <= nq[i];
            count_q     <= count_q + CNT_W'(dispatch) - CNT_W'(issue);
            iss_valid_q <= issue;
            if (issue) begin
                iss_inst_q    <= q[sel].inst;
                iss_inst_id_q <= q[sel].inst_id;
                iss_out_prn_q <= q[sel].out_prn;
                iss_op_q      <= q[sel].val;
            end
        end
    end

    assign bus.disp_ready  = disp_ready;
    assign bus.count       = count_q;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.iss_inst    = iss_inst_q;
    assign bus.iss_inst_id = iss_inst_id_q;
    assign bus.iss_out_prn = iss_out_prn_q;
    assign bus.iss_op      = iss_op_q;
endmodule

// File: tb/tb_rs_arith.sv
// tb_rs_arith: self-checking bench for rs_arith. Expected issues are queued
// when dispatched and compared in order as iss_valid appears; directed
// sequences check latency, wakeup, back-pressure, flush and async reset.
module tb_rs_arith;
    localparam int ENTRIES = 4;
    localparam int PRN_W   = 7;
    localparam int ID_W    = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_arith_if #(.ENTRIES(ENTRIES), .PRN_W(PRN_W), .ID_W(ID_W)) bus();

    rs_arith #(.ENTRIES(ENTRIES), .PRN_W(PRN_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]      inst;
        logic [ID_W-1:0]  id;
        logic [PRN_W-1:0] prn;
        logic [63:0]      op0;
        logic [63:0]      op1;
    } exp_t;

    typedef struct {
        logic [31:0]      inst;
        logic [ID_W-1:0]  id;
        logic [PRN_W-1:0] prn;
        logic [PRN_W-1:0] sp0;
        logic [PRN_W-1:0] sp1;
        logic [63:0]      v0;
        logic [63:0]      v1;
        exp_t             exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[6];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.wb_valid   = 1'b0;
    endtask

    task automatic drive_disp(input logic [31:0] inst, input logic [ID_W-1:0] id,
                              input logic [PRN_W-1:0] oprn, input logic [PRN_W-1:0] p0,
                              input logic [PRN_W-1:0] p1, input logic [1:0] rdy,
                              input logic [63:0] v0, input logic [63:0] v1);
        bus.disp_valid      = 1'b1;
        bus.disp_inst       = inst;
        bus.disp_inst_id    = id;
        bus.disp_out_prn    = oprn;
        bus.disp_src_prn[0] = p0;
        bus.disp_src_prn[1] = p1;
        bus.disp_src_rdy    = rdy;
        bus.disp_src_val[0] = v0;
        bus.disp_src_val[1] = v1;
    endtask

    task automatic wb(input logic [PRN_W-1:0] prn, input logic [63:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_prn   = prn;
        bus.wb_data  = data;
    endtask

    task automatic push(input logic [31:0] inst, input logic [ID_W-1:0] id,
                        input logic [PRN_W-1:0] prn, input logic [63:0] op0, input logic [63:0] op1);
        exp_t e;
        e.inst = inst; e.id = id; e.prn = prn; e.op0 = op0; e.op1 = op1;
        sb.push_back(e);
    endtask

    // Issue monitor: every iss_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.iss_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got iss_inst 0x%0h, expected no issue", bus.iss_inst);
            end else begin
                mon_e = sb.pop_front();
                chk("iss_inst",    64'(bus.iss_inst),    64'(mon_e.inst));
                chk("iss_inst_id", 64'(bus.iss_inst_id), 64'(mon_e.id));
                chk("iss_out_prn", 64'(bus.iss_out_prn), 64'(mon_e.prn));
                chk("iss_op0",     bus.iss_op[0],        mon_e.op0);
                chk("iss_op1",     bus.iss_op[1],        mon_e.op1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0000_0033, 6'd3,  7'd11, 7'd1,  7'd2,  64'd100,              64'd200,              '{32'h0000_0033, 6'd3,  7'd11, 64'd100,              64'd200}};
        tbl[1] = '{32'hFFFF_FFFF, 6'h3F, 7'h7F, 7'h7F, 7'h7E, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,              '{32'hFFFF_FFFF, 6'h3F, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0}};
        tbl[2] = '{32'h0000_0000, 6'd0,  7'd0,  7'd0,  7'd0,  64'h0,                64'hFFFF_FFFF_FFFF_FFFF, '{32'h0000_0000, 6'd0,  7'd0,  64'h0,                64'hFFFF_FFFF_FFFF_FFFF}};
        tbl[3] = '{32'h4000_00B3, 6'd21, 7'd64, 7'd5,  7'd6,  64'h8000_0000_0000_0000, 64'h1,              '{32'h4000_00B3, 6'd21, 7'd64, 64'h8000_0000_0000_0000, 64'h1}};
        tbl[4] = '{32'h00A5_0013, 6'd42, 7'd33, 7'd9,  7'd0,  64'hDEAD_BEEF_0BAD_F00D, 64'hA5A5_A5A5_5A5A_5A5A, '{32'h00A5_0013, 6'd42, 7'd33, 64'hDEAD_BEEF_0BAD_F00D, 64'hA5A5_A5A5_5A5A_5A5A}};
        tbl[5] = '{32'h1234_5678, 6'd7,  7'd99, 7'd3,  7'd4,  64'd42,               64'd24,               '{32'h1234_5678, 6'd7,  7'd99, 64'd42,               64'd24}};

        idle();
        bus.fu_ready     = 1'b0;
        bus.disp_inst    = '0;
        bus.disp_inst_id = '0;
        bus.disp_out_prn = '0;
        bus.disp_src_prn = '0;
        bus.disp_src_rdy = '0;
        bus.disp_src_val = '0;
        bus.wb_prn       = '0;
        bus.wb_data      = '0;
        rst = 1'b1;
        #2;
        chk("rst_count",      64'(bus.count),      64'd0);
        chk("rst_iss_valid",  64'(bus.iss_valid),  64'd0);
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_iss_inst",   64'(bus.iss_inst),   64'd0);
        chk("rst_iss_op0",    bus.iss_op[0],       64'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Minimum latency: dispatch ready op in cycle 0, issue visible in cycle 2.
        bus.fu_ready = 1'b1;
        drive_disp(32'h0000_0033, 6'd1, 7'd10, 7'd1, 7'd2, 2'b11, 64'd5, 64'd6);
        push(32'h0000_0033, 6'd1, 7'd10, 64'd5, 64'd6);
        step(); idle();
        chk("lat_c1_iss_valid", 64'(bus.iss_valid), 64'd0);
        chk("lat_c1_count",     64'(bus.count),     64'd1);
        step();
        chk("lat_c2_iss_valid", 64'(bus.iss_valid), 64'd1);
        chk("lat_c2_count",     64'(bus.count),     64'd0);

        // Back-to-back table of ready dispatches.
        for (int i = 0; i < 6; i++) begin
            drive_disp(tbl[i].inst, tbl[i].id, tbl[i].prn, tbl[i].sp0, tbl[i].sp1, 2'b11, tbl[i].v0, tbl[i].v1);
            push(tbl[i].exp.inst, tbl[i].exp.id, tbl[i].exp.prn, tbl[i].exp.op0, tbl[i].exp.op1);
            step();
        end
        idle();
        repeat (3) step();
        chk("tbl_drain_count", 64'(bus.count), 64'd0);

        // Younger ready entry bypasses older waiting one; wakeup releases the older.
        drive_disp(32'h0000_00AA, 6'd2, 7'd20, 7'd9, 7'd4, 2'b10, 64'hBAD, 64'd2);
        step();
        drive_disp(32'h0000_00BB, 6'd3, 7'd21, 7'd5, 7'd6, 2'b11, 64'd11, 64'd12);
        push(32'h0000_00BB, 6'd3, 7'd21, 64'd11, 64'd12);
        push(32'h0000_00AA, 6'd2, 7'd20, 64'h1234, 64'd2);
        step(); idle();
        step();
        wb(7'd8, 64'hDEAD);
        chk("ooo_b_iss_valid", 64'(bus.iss_valid), 64'd1);
        step();
        wb(7'd9, 64'h1234);
        chk("ooo_a_not_early", 64'(bus.iss_valid), 64'd0);
        step(); idle();
        chk("ooo_wake_n1",     64'(bus.iss_valid), 64'd0);
        step();
        chk("ooo_wake_n2",     64'(bus.iss_valid), 64'd1);
        chk("ooo_count",       64'(bus.count),     64'd0);

        // Full queue back-pressure, then in-order drain.
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_disp(32'h100 + 32'(i), 6'(10 + i), 7'(30 + i), 7'd1, 7'd2, 2'b11, 64'(i * 100), 64'(i));
            push(32'h100 + 32'(i), 6'(10 + i), 7'(30 + i), 64'(i * 100), 64'(i));
            step();
        end
        idle();
        chk("full_count",      64'(bus.count),      64'd4);
        chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
        drive_disp(32'h0000_0555, 6'd55, 7'd55, 7'd1, 7'd2, 2'b11, 64'd55, 64'd55);
        step(); idle();
        chk("full_fifth_drop", 64'(bus.count), 64'd4);
        bus.fu_ready = 1'b1;
        step();
        chk("full_first_iss",   64'(bus.iss_valid),  64'd1);
        chk("full_after_count", 64'(bus.count),      64'd3);
        chk("full_after_ready", 64'(bus.disp_ready), 64'd1);
        repeat (4) step();
        chk("full_drain_count", 64'(bus.count), 64'd0);

        // Wakeup of a source on the very cycle it is dispatched.
        drive_disp(32'h0000_00DD, 6'd40, 7'd50, 7'd1, 7'd3, 2'b01, 64'd77, 64'hBAD);
        wb(7'd3, 64'd7);
        push(32'h0000_00DD, 6'd40, 7'd50, 64'd77, 64'd7);
        step(); idle();
        chk("samecyc_c1_iss_valid", 64'(bus.iss_valid), 64'd0);
        step();
        chk("samecyc_c2_iss_valid", 64'(bus.iss_valid), 64'd1);

        // Flush with three held entries and a concurrent dispatch.
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_disp(32'h200 + 32'(i), 6'(20 + i), 7'(40 + i), 7'd1, 7'd2, 2'b11, 64'(i), 64'(i));
            step();
        end
        idle();
        chk("flush_pre_count", 64'(bus.count), 64'd3);
        bus.fu_ready = 1'b1;
        bus.flush    = 1'b1;
        drive_disp(32'h0000_0FFF, 6'd60, 7'd60, 7'd1, 7'd2, 2'b11, 64'd1, 64'd1);
        step(); idle();
        chk("flush_count",     64'(bus.count),     64'd0);
        chk("flush_iss_valid", 64'(bus.iss_valid), 64'd0);
        repeat (3) step();
        chk("flush_post_count", 64'(bus.count), 64'd0);
        drive_disp(32'h0000_0777, 6'd17, 7'd70, 7'd1, 7'd2, 2'b11, 64'd9, 64'd8);
        push(32'h0000_0777, 6'd17, 7'd70, 64'd9, 64'd8);
        step(); idle();
        repeat (3) step();

        // Asynchronous reset mid-cycle with two entries held.
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_disp(32'h300 + 32'(i), 6'(30 + i), 7'(80 + i), 7'd1, 7'd2, 2'b11, 64'(i + 1), 64'(i + 2));
            step();
        end
        idle();
        push(32'h300, 6'd30, 7'd80, 64'd1, 64'd2);
        bus.fu_ready = 1'b1;
        step();
        bus.fu_ready = 1'b0;
        chk("rst_mid_pre_count", 64'(bus.count), 64'd2);
        #5;
        rst = 1'b1;
        #1;
        chk("rst_mid_count",      64'(bus.count),      64'd0);
        chk("rst_mid_iss_valid",  64'(bus.iss_valid),  64'd0);
        chk("rst_mid_disp_ready", 64'(bus.disp_ready), 64'd1);
        #2;
        rst = 1'b0;
        bus.fu_ready = 1'b1;
        repeat (4) step();
        chk("rst_post_count", 64'(bus.count), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rs_arith.md
RS_ARITH -- requirements
Module: rs_arith

Interface
REQ-001 Parameter ENTRIES, default 4, SHALL set queue depth (power of two, >= 2).
REQ-002 Parameter PRN_W, default 7, SHALL set physical register number width.
REQ-003 Parameter ID_W, default 6, SHALL set instruction ID width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 flush  in  1  SHALL discard all held and in-flight work.
REQ-007 disp_valid  in  1  SHALL mark a dispatch offer.
REQ-008 disp_ready  out  1  SHALL indicate space for one dispatch.
REQ-009 disp_inst  in  32  SHALL carry the raw instruction word.
REQ-010 disp_inst_id  in  ID_W  SHALL carry the ROB instruction ID.
REQ-011 disp_out_prn  in  PRN_W  SHALL carry the destination PRN.
REQ-012 disp_src_prn[2]  in  2xPRN_W  SHALL carry the source PRNs for op0 and op1.
REQ-013 disp_src_rdy[2]  in  2  SHALL mark each source value as already available; dispatch sets bit 1 for immediate-form ops.
REQ-014 disp_src_val[2]  in  2x64  SHALL carry source values, valid where the rdy bit is set.
REQ-015 wb_valid  in  1  SHALL mark a result broadcast.
REQ-016 wb_prn  in  PRN_W  SHALL carry the result PRN.
REQ-017 wb_data  in  64  SHALL carry the result value.
REQ-018 fu_ready  in  1  SHALL indicate the arith FU accepts an instruction this cycle.
REQ-019 iss_valid  out  1  SHALL drive FU inst_valid, registered.
REQ-020 iss_inst, iss_inst_id, iss_out_prn, iss_op[2]  out  32/ID_W/PRN_W/2x64  SHALL drive FU inst, inst_id, out_prn and op[0..1], registered.
REQ-021 count  out  clog2(ENTRIES)+1  SHALL report occupied entries.

Function
REQ-022 Each entry SHALL hold: valid, inst, inst_id, out_prn, per source {prn, rdy, val}.
REQ-023 Entries SHALL form a collapsing queue; index 0 is the oldest.
REQ-024 disp_ready SHALL equal (count != ENTRIES), from registered state only; same-cycle issue does not free space.
REQ-025 A dispatch SHALL occur when disp_valid && disp_ready && !flush; the entry is written at the edge ending that cycle.
REQ-026 Dispatched entry SHALL land at index count, or count-1 if an issue removes an entry in the same cycle.
REQ-027 Wakeup: when wb_valid, every valid entry source with rdy=0 and prn==wb_prn SHALL set rdy=1 and capture wb_data at the edge.
REQ-028 Wakeup SHALL also apply to the entry dispatched in the same cycle: non-ready source with matching prn is written rdy=1 with wb_data.
REQ-029 An entry SHALL be eligible when valid and both rdy bits are set in registered state; wakeups captured this cycle count next cycle.
REQ-030 When fu_ready && !flush and an eligible entry exists, the lowest-index eligible entry SHALL be issued: its fields are loaded into the iss_* registers, it is removed, and higher entries shift down one.
REQ-031 iss_valid SHALL be 1 in the cycle after each issue and 0 otherwise; iss_* data registers hold their value when no issue occurs.
REQ-032 At most one issue and one dispatch SHALL occur per cycle.
REQ-033 Minimum latency SHALL be 2 cycles: dispatch in cycle N with both rdy -> iss_valid in cycle N+2.
REQ-034 Wakeup in cycle N of the last missing source -> iss_valid no earlier than N+2.
REQ-035 flush SHALL, at the next edge, clear all entry valids, set count=0 and iss_valid=0, overriding dispatch, wakeup and issue.
REQ-036 count SHALL update as count + dispatch - issue and never exceed ENTRIES or go below 0.

Reset
REQ-037 On rst assertion, asynchronously: all entry valids=0, count=0, iss_valid=0, disp_ready=1.
REQ-038 iss_inst, iss_inst_id, iss_out_prn, iss_op SHALL reset to 0; entry payloads need not be reset.
REQ-039 rst mid-operation SHALL drop all entries with no issue in the cycle following deassertion.

Verification
REQ-040 Dispatch ADD (disp_src_rdy=2'b11, op0=5) with fu_ready=1 in cycle 0 -> iss_valid=1 in cycle 2, iss_op[0]=5, count back to 0 in cycle 2.
REQ-041 Dispatch A (src0 prn 9 not ready) then B (ready) -> B issues first; wb_valid, wb_prn=9, wb_data=0x1234 -> A issues 2 cycles later with iss_op[0]=0x1234.
REQ-042 Fill 4 entries, fu_ready=0 -> disp_ready=0, count=4; fifth disp_valid ignored; fu_ready=1 -> issues in order 0..3, disp_ready=1 the cycle after the first issue.
REQ-043 Dispatch with src1 prn 3 not ready while wb_valid, wb_prn=3, wb_data=7 in the same cycle -> entry issues with iss_op[1]=7, no stall.
REQ-044 Three entries held, pending issue, flush=1 for one cycle -> count=0, iss_valid=0 next cycle; a concurrent dispatch is dropped.
REQ-045 rst pulsed asynchronously mid-cycle with 2 entries -> count=0, iss_valid=0 immediately; no issue after deassertion.
